io_irq_ctrl: RTL and testbench

- Input conditioning and interrupt stage between the board switch/button pins and the AXI4-Lite register map.
- Synchronises and debounces 8 switches and 5 buttons, then detects enabled edges.
- Keeps sticky per-bit interrupt status and drives one level interrupt to the PS.
- Consumes the enable, clear, edge-select, debounce and test controls from the register map. Returns the debounced levels (register 0x04) and the status (register 0x08).

---
 rtl/io_irq_ctrl.sv | 119 +++++++++++
 tb/tb_io_irq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_irq_ctrl.sv
// Switch/button input conditioning: 2-FF sync, tick-based debounce, edge detect,
// sticky interrupt status and a single registered level interrupt.
module io_irq_ctrl #(
   parameter int unsigned TICK_DIV = 100000
) (
   input  logic       ACLK,
   input  logic       ARESETn,
   input  logic [7:0] sw_in,
   input  logic [4:0] btn_in,
   input  logic [7:0] deb_switch_ena,
   input  logic [4:0] deb_button_ena,
   input  logic [4:0] deb_time,
   input  logic [7:0] int_switch_ena,
   input  logic [4:0] int_button_ena,
   input  logic [7:0] int_switch_clr,
   input  logic [4:0] int_button_clr,
   input  logic [4:0] button_posedge,
   input  logic [4:0] button_negedge,
   input  logic       invoke_int_test,
   output logic [7:0] switch,
   output logic [4:0] button,
   output logic [7:0] int_switch_sts,
   output logic [4:0] int_button_sts,
   output logic       irq
);

   localparam int unsigned N_SW   = 8;
   localparam int unsigned N_BTN  = 5;
   localparam int unsigned N_IN   = N_SW + N_BTN;
   localparam int unsigned DEB_W  = 5;
   localparam int unsigned TICK_W = $clog2(TICK_DIV);

   logic [N_IN-1:0]   sync_q1;
   logic [N_IN-1:0]   sync_q2;
   logic [N_IN-1:0]   stable_q;
   logic [N_IN-1:0]   prev_q;
   logic [N_IN-1:0]   deb_ena;
   logic [DEB_W-1:0]  deb_cnt_q [N_IN];
   logic [TICK_W-1:0] tick_cnt_q;
   logic              tick;
   logic [N_SW-1:0]   sw_evt;
   logic [N_BTN-1:0]  btn_rise;
   logic [N_BTN-1:0]  btn_fall;

   assign deb_ena = {deb_button_ena, deb_switch_ena};
   assign tick    = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

   // Two-stage synchroniser for the asynchronous pins
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= {btn_in, sw_in};
         sync_q2 <= sync_q1;
      end
   end

   // Free-running debounce tick divider
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         tick_cnt_q <= '0;
      end else if (tick) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_q + TICK_W'(1);
      end
   end

   // Per-bit debounce: a level must disagree for deb_time+1 ticks to be accepted
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         stable_q <= '0;
         for (int unsigned i = 0; i < N_IN; i++) begin
            deb_cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N_IN; i++) begin
            if (!deb_ena[i]) begin
               stable_q[i]  <= sync_q2[i];
               deb_cnt_q[i] <= '0;
            end else if (sync_q2[i] == stable_q[i]) begin
               deb_cnt_q[i] <= '0;
            end else if (tick) begin
               if (deb_cnt_q[i] >= deb_time) begin
                  stable_q[i]  <= sync_q2[i];
                  deb_cnt_q[i] <= '0;
               end else begin
                  deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
               end
            end
         end
      end
   end

   assign sw_evt   = (stable_q[N_SW-1:0] ^ prev_q[N_SW-1:0]) & int_switch_ena;
   assign btn_rise = stable_q[N_IN-1:N_SW] & ~prev_q[N_IN-1:N_SW] & button_posedge & int_button_ena;
   assign btn_fall = ~stable_q[N_IN-1:N_SW] & prev_q[N_IN-1:N_SW] & button_negedge & int_button_ena;

   // Sticky status: set (event or test) dominates clear; irq masks with live enables
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         prev_q         <= '0;
         int_switch_sts <= '0;
         int_button_sts <= '0;
         irq            <= 1'b0;
      end else begin
         prev_q         <= stable_q;
         int_switch_sts <= (int_switch_sts & ~int_switch_clr) | sw_evt | {N_SW{invoke_int_test}};
         int_button_sts <= (int_button_sts & ~int_button_clr) | btn_rise | btn_fall
                           | {N_BTN{invoke_int_test}};
         irq            <= (|(int_switch_sts & int_switch_ena)) | (|(int_button_sts & int_button_ena));
      end
   end

   assign switch = stable_q[N_SW-1:0];
   assign button = stable_q[N_IN-1:N_SW];

endmodule

// File: tb/tb_io_irq_ctrl.sv
// Self-checking bench for io_irq_ctrl: directed scenarios plus a randomized run
// against a pin-history reference model (debounce off).
module tb_io_irq_ctrl;

   localparam int unsigned TICK_DIV = 4;
   localparam int NR = 400;

   logic       ACLK;
   logic       ARESETn;
   logic [7:0] sw_in;
   logic [4:0] btn_in;
   logic [7:0] deb_switch_ena;
   logic [4:0] deb_button_ena;
   logic [4:0] deb_time;
   logic [7:0] int_switch_ena;
   logic [4:0] int_button_ena;
   logic [7:0] int_switch_clr;
   logic [4:0] int_button_clr;
   logic [4:0] button_posedge;
   logic [4:0] button_negedge;
   logic       invoke_int_test;
   logic [7:0] switch;
   logic [4:0] button;
   logic [7:0] int_switch_sts;
   logic [4:0] int_button_sts;
   logic       irq;

   int n_tests;
   int n_fail;
   int unsigned ecnt;

   io_irq_ctrl #(.TICK_DIV(TICK_DIV)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .sw_in(sw_in), .btn_in(btn_in),
      .deb_switch_ena(deb_switch_ena), .deb_button_ena(deb_button_ena), .deb_time(deb_time),
      .int_switch_ena(int_switch_ena), .int_button_ena(int_button_ena),
      .int_switch_clr(int_switch_clr), .int_button_clr(int_button_clr),
      .button_posedge(button_posedge), .button_negedge(button_negedge),
      .invoke_int_test(invoke_int_test), .switch(switch), .button(button),
      .int_switch_sts(int_switch_sts), .int_button_sts(int_button_sts), .irq(irq)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Edges since reset release; the tick fires on edges that are multiples of TICK_DIV
   always @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) ecnt <= 0;
      else          ecnt <= ecnt + 1;
   end

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic zero_inputs();
      sw_in = '0; btn_in = '0; deb_switch_ena = '0; deb_button_ena = '0; deb_time = '0;
      int_switch_ena = '0; int_button_ena = '0; int_switch_clr = '0; int_button_clr = '0;
      button_posedge = '0; button_negedge = '0; invoke_int_test = 1'b0;
   endtask

   task automatic do_reset();
      zero_inputs();
      ARESETn = 1'b0;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      ARESETn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (switch !== 8'h00) begin n_fail++; $display("FAIL reset_switch: got %h want 00", switch); end
      n_tests++; if (button !== 5'h00) begin n_fail++; $display("FAIL reset_button: got %h want 00", button); end
      n_tests++; if (int_switch_sts !== 8'h00) begin n_fail++; $display("FAIL reset_sw_sts: got %h want 00", int_switch_sts); end
      n_tests++; if (int_button_sts !== 5'h00) begin n_fail++; $display("FAIL reset_btn_sts: got %h want 00", int_button_sts); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
   endtask

   task automatic test_latency();
      do_reset();
      int_switch_ena = 8'h01;
      repeat (3) step();
      sw_in = 8'h01;
      step();   // edge k
      step();   // k+1
      n_tests++; if (switch !== 8'h00) begin n_fail++; $display("FAIL lat_sw_k1: got %h want 00", switch); end
      step();   // k+2
      n_tests++; if (switch !== 8'h01) begin n_fail++; $display("FAIL lat_sw_k2: got %h want 01", switch); end
      n_tests++; if (int_switch_sts !== 8'h00) begin n_fail++; $display("FAIL lat_sts_k2: got %h want 00", int_switch_sts); end
      step();   // k+3
      n_tests++; if (int_switch_sts !== 8'h01) begin n_fail++; $display("FAIL lat_sts_k3: got %h want 01", int_switch_sts); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL lat_irq_k3: got %b want 0", irq); end
      step();   // k+4
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL lat_irq_k4: got %b want 1", irq); end
      int_switch_clr = 8'h01;
      step();
      int_switch_clr = 8'h00;
      n_tests++; if (int_switch_sts !== 8'h00) begin n_fail++; $display("FAIL clr_sts: got %h want 00", int_switch_sts); end
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL clr_irq_hold: got %b want 1", irq); end
      step();
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL clr_irq_drop: got %b want 0", irq); end
   endtask

   task automatic test_debounce();
      int unsigned k;
      int unsigned exp_e;
      int bad;
      do_reset();
      deb_time = 5'd2;
      deb_button_ena = 5'h01;
      bad = 0;
      for (int g = 0; g < 3; g++) begin
         btn_in = 5'h01;
         repeat (4) begin step(); if (button !== 5'h00) bad++; end
         btn_in = 5'h00;
         repeat (6) begin step(); if (button !== 5'h00) bad++; end
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL deb_glitch: %0d cycles with button high, want 0", bad); end
      btn_in = 5'h01;
      step();
      k = ecnt;
      exp_e = k + 2;
      while (exp_e % TICK_DIV != 0) exp_e++;
      exp_e = exp_e + 2 * TICK_DIV;
      while (ecnt + 1 < exp_e) step();
      n_tests++; if (button !== 5'h00) begin n_fail++; $display("FAIL deb_early: got %h want 00", button); end
      step();
      n_tests++; if (button !== 5'h01) begin n_fail++; $display("FAIL deb_third_tick: got %h want 01", button); end
   endtask

   task automatic test_edge_select();
      do_reset();
      int_button_ena = 5'h01;
      button_posedge = 5'h01;
      button_negedge = 5'h00;
      btn_in = 5'h01;
      repeat (6) step();
      n_tests++; if (int_button_sts !== 5'h01) begin n_fail++; $display("FAIL pos_press: got %h want 01", int_button_sts); end
      int_button_clr = 5'h01; step(); int_button_clr = 5'h00;
      btn_in = 5'h00;
      repeat (6) step();
      n_tests++; if (int_button_sts !== 5'h00) begin n_fail++; $display("FAIL pos_release: got %h want 00", int_button_sts); end
      button_posedge = 5'h00;
      button_negedge = 5'h01;
      btn_in = 5'h01;
      repeat (6) step();
      n_tests++; if (int_button_sts !== 5'h00) begin n_fail++; $display("FAIL neg_press: got %h want 00", int_button_sts); end
      btn_in = 5'h00;
      repeat (6) step();
      n_tests++; if (int_button_sts !== 5'h01) begin n_fail++; $display("FAIL neg_release: got %h want 01", int_button_sts); end
   endtask

   task automatic test_mask();
      int_button_ena = 5'h00;
      repeat (2) step();
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq: got %b want 0", irq); end
      n_tests++; if (int_button_sts !== 5'h01) begin n_fail++; $display("FAIL mask_sts: got %h want 01", int_button_sts); end
      int_button_ena = 5'h01;
      step();
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL unmask_irq: got %b want 1", irq); end
   endtask

   task automatic test_int_test();
      do_reset();
      repeat (2) step();
      invoke_int_test = 1'b1;
      int_switch_clr = 8'hFF;
      step();
      invoke_int_test = 1'b0;
      int_switch_clr = 8'h00;
      n_tests++; if (int_switch_sts !== 8'hFF) begin n_fail++; $display("FAIL test_sw_sts: got %h want ff", int_switch_sts); end
      n_tests++; if (int_button_sts !== 5'h1F) begin n_fail++; $display("FAIL test_btn_sts: got %h want 1f", int_button_sts); end
      step();
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL test_irq_masked: got %b want 0", irq); end
      int_button_ena = 5'h10;
      step();
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL test_irq_btn4: got %b want 1", irq); end
   endtask

   task automatic test_reset_mid();
      int waited;
      int bad;
      do_reset();
      deb_switch_ena = 8'hFF;
      deb_time = 5'd3;
      sw_in = 8'hAA;
      repeat (6) step();
      invoke_int_test = 1'b1; step(); invoke_int_test = 1'b0;
      step();
      @(posedge ACLK);
      #3;
      ARESETn = 1'b0;
      #1;
      n_tests++; if (int_switch_sts !== 8'h00) begin n_fail++; $display("FAIL rmid_sw_sts: got %h want 00", int_switch_sts); end
      n_tests++; if (int_button_sts !== 5'h00) begin n_fail++; $display("FAIL rmid_btn_sts: got %h want 00", int_button_sts); end
      n_tests++; if (switch !== 8'h00 || button !== 5'h00 || irq !== 1'b0) begin
         n_fail++; $display("FAIL rmid_levels: got sw=%h btn=%h irq=%b want 0", switch, button, irq);
      end
      @(negedge ACLK);
      ARESETn = 1'b1;
      sw_in = 8'hFF;
      deb_time = 5'd1;
      repeat (3) step();
      n_tests++; if (switch !== 8'h00) begin n_fail++; $display("FAIL rmid_deb_early: got %h want 00", switch); end
      waited = 0;
      bad = 0;
      while (switch !== 8'hFF && waited < 60) begin
         step();
         waited++;
         if (int_switch_sts !== 8'h00) bad++;
      end
      n_tests++; if (switch !== 8'hFF) begin n_fail++; $display("FAIL rmid_timeout: got %h want ff", switch); end
      repeat (4) begin step(); if (int_switch_sts !== 8'h00) bad++; end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rmid_sts: %0d cycles with status set, want 0", bad); end
   endtask

   // Random pins/enables/clears with debounce off, checked against pin history
   task automatic test_random();
      logic [7:0] sw_h [0:NR+3];
      logic [4:0] bt_h [0:NR+3];
      logic [7:0] m_sw;
      logic [4:0] m_bt;
      logic [7:0] evt_sw;
      logic [4:0] evt_bt;
      logic       exp_irq;
      int bad_lvl, bad_sts, bad_irq;
      do_reset();
      repeat (4) step();
      for (int i = 0; i < 4; i++) begin sw_h[i] = '0; bt_h[i] = '0; end
      m_sw = '0; m_bt = '0;
      bad_lvl = 0; bad_sts = 0; bad_irq = 0;
      for (int n = 4; n < NR + 4; n++) begin
         if ($urandom_range(3) == 0) sw_in = 8'($urandom);
         if ($urandom_range(3) == 0) btn_in = 5'($urandom);
         if ($urandom_range(15) == 0) int_switch_ena = 8'($urandom);
         if ($urandom_range(15) == 0) int_button_ena = 5'($urandom);
         if ($urandom_range(15) == 0) button_posedge = 5'($urandom);
         if ($urandom_range(15) == 0) button_negedge = 5'($urandom);
         int_switch_clr  = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
         int_button_clr  = ($urandom_range(3) == 0) ? 5'($urandom) : 5'h00;
         invoke_int_test = ($urandom_range(31) == 0);
         sw_h[n] = sw_in;
         bt_h[n] = btn_in;
         step();
         exp_irq = (|(m_sw & int_switch_ena)) | (|(m_bt & int_button_ena));
         evt_sw  = (sw_h[n-3] ^ sw_h[n-4]) & int_switch_ena;
         evt_bt  = ((bt_h[n-3] & ~bt_h[n-4] & button_posedge)
                   | (~bt_h[n-3] & bt_h[n-4] & button_negedge)) & int_button_ena;
         m_sw = (m_sw & ~int_switch_clr) | evt_sw | {8{invoke_int_test}};
         m_bt = (m_bt & ~int_button_clr) | evt_bt | {5{invoke_int_test}};
         if (switch !== sw_h[n-2] || button !== bt_h[n-2]) begin
            bad_lvl++;
            if (bad_lvl < 4) $display("FAIL rnd_level @%0d: got sw=%h btn=%h want sw=%h btn=%h",
                                      n, switch, button, sw_h[n-2], bt_h[n-2]);
         end
         if (int_switch_sts !== m_sw || int_button_sts !== m_bt) begin
            bad_sts++;
            if (bad_sts < 4) $display("FAIL rnd_sts @%0d: got sw=%h btn=%h want sw=%h btn=%h",
                                      n, int_switch_sts, int_button_sts, m_sw, m_bt);
         end
         if (irq !== exp_irq) begin
            bad_irq++;
            if (bad_irq < 4) $display("FAIL rnd_irq @%0d: got %b want %b", n, irq, exp_irq);
         end
      end
      n_tests++; if (bad_lvl != 0) begin n_fail++; $display("FAIL rnd_level_total: %0d bad cycles, want 0", bad_lvl); end
      n_tests++; if (bad_sts != 0) begin n_fail++; $display("FAIL rnd_sts_total: %0d bad cycles, want 0", bad_sts); end
      n_tests++; if (bad_irq != 0) begin n_fail++; $display("FAIL rnd_irq_total: %0d bad cycles, want 0", bad_irq); end
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      ARESETn = 1'b0;
      zero_inputs();
      test_reset();
      test_latency();
      test_debounce();
      test_edge_select();
      test_mask();
      test_int_test();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
